// File: rtl/clk_div_arbiter_pkg.sv
// Shared types for the clock-divider arbiter: FSM state encoding and the
// default divider ratio width/type.
package clk_div_arb_pkg;

    localparam int DIV_W_DEFAULT = 32;

    typedef logic [DIV_W_DEFAULT-1:0] ratio_t;

    typedef enum logic [1:0] {
        IDLE,
        DISABLE,
        CONFIG,
        RUN
    } arb_state_t;

endpackage

// File: rtl/clk_div_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping around, reported as one-hot plus index.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] winOneHot,
    output logic [IDXW-1:0]    winIdx,
    output logic               valid
);

    int              cand;
    logic [IDXW-1:0] candIdx;

    // Scan from the pointer upward; the first hit is the winner.
    always_comb begin
        winOneHot = '0;
        winIdx    = '0;
        valid     = 1'b0;
        cand      = 0;
        candIdx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IDXW'(cand);
            if (!valid && req[candIdx]) begin
                valid              = 1'b1;
                winIdx             = candIdx;
                winOneHot[candIdx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_arbiter.sv
// Round-robin owner of a shared programmable clock divider: disable, settle,
// load ratio, enable, hold until release. Optional forced revoke: CLK_DIV_ARB_TIMEOUT_EN.
module clk_div_arbiter
    import clk_div_arb_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DIV_W         = DIV_W_DEFAULT,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_HOLD      = 1024
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [NUM_REQ-1:0]       Req,
    input  logic [NUM_REQ*DIV_W-1:0] ReqDiv,
    output logic [NUM_REQ-1:0]       Grant,
    output logic                     Busy,
    output logic [NUM_REQ-1:0]       Revoked,
    output logic                     DivEnable,
    output logic                     DivConfig,
    output logic [DIV_W-1:0]         DivDin
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int SCW  = $clog2(SETTLE_CYCLES + 1);

    arb_state_t         state, nextState;
    logic [IDXW-1:0]    rrPtr, ownerIdx, arbIdx, nextPtr;
    logic [NUM_REQ-1:0] arbOneHot, ownerOneHot;
    logic               arbValid, loadOwner, loadDin, ptrAdvance, ownerReq;
    logic [SCW-1:0]     settleCnt;
    logic [DIV_W-1:0]   latchedDiv;
    logic               revokeFire;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) uArb (
        .req       (Req),
        .ptr       (rrPtr),
        .winOneHot (arbOneHot),
        .winIdx    (arbIdx),
        .valid     (arbValid)
    );

    assign ownerOneHot = NUM_REQ'(1) << ownerIdx;
    assign ownerReq    = Req[ownerIdx];
    assign nextPtr     = (ownerIdx == IDXW'(NUM_REQ - 1)) ? '0 : ownerIdx + IDXW'(1);

`ifdef CLK_DIV_ARB_TIMEOUT_EN
    localparam logic [31:0] HOLD_MAX  = 32'(MAX_HOLD);
    localparam logic [31:0] HOLD_LAST = 32'(MAX_HOLD - 1);

    logic [31:0]        holdCnt;
    logic [NUM_REQ-1:0] revokedQ;
    logic               otherReq;

    assign otherReq = (Req & ~ownerOneHot) != '0;
    assign Revoked  = revokedQ;

    // Counts RUN cycles from zero at RUN entry and saturates at the limit.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            holdCnt  <= '0;
            revokedQ <= '0;
        end else begin
            revokedQ <= revokeFire ? ownerOneHot : '0;
            if (state != RUN) begin
                holdCnt <= '0;
            end else if (holdCnt != HOLD_MAX) begin
                holdCnt <= holdCnt + 32'd1;
            end
        end
    end
`else
    assign Revoked = '0;
`endif

    // Dropping the owner's request in any active state returns to IDLE and
    // still advances the pointer, so an aborted requester loses its turn.
    always_comb begin
        nextState  = state;
        loadOwner  = 1'b0;
        loadDin    = 1'b0;
        ptrAdvance = 1'b0;
        revokeFire = 1'b0;
        unique case (state)
            IDLE: begin
                if (arbValid) begin
                    nextState = DISABLE;
                    loadOwner = 1'b1;
                end
            end
            DISABLE: begin
                if (!ownerReq) begin
                    nextState  = IDLE;
                    ptrAdvance = 1'b1;
                end else if (settleCnt == SCW'(SETTLE_CYCLES - 1)) begin
                    nextState = CONFIG;
                    loadDin   = 1'b1;
                end
            end
            CONFIG: begin
                if (!ownerReq) begin
                    nextState  = IDLE;
                    ptrAdvance = 1'b1;
                end else begin
                    nextState = RUN;
                end
            end
            RUN: begin
                if (!ownerReq) begin
                    nextState  = IDLE;
                    ptrAdvance = 1'b1;
`ifdef CLK_DIV_ARB_TIMEOUT_EN
                end else if (holdCnt >= HOLD_LAST && otherReq) begin
                    nextState  = IDLE;
                    ptrAdvance = 1'b1;
                    revokeFire = 1'b1;
`endif
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            rrPtr      <= '0;
            ownerIdx   <= '0;
            settleCnt  <= '0;
            latchedDiv <= '0;
            DivDin     <= '0;
        end else begin
            state     <= nextState;
            settleCnt <= (state == DISABLE) ? settleCnt + SCW'(1) : '0;
            if (loadOwner) begin
                ownerIdx   <= arbIdx;
                latchedDiv <= ReqDiv[arbIdx*DIV_W +: DIV_W];
            end
            if (loadDin) begin
                DivDin <= latchedDiv;
            end
            if (ptrAdvance) begin
                rrPtr <= nextPtr;
            end
        end
    end

    assign Busy      = state != IDLE;
    assign DivEnable = state == RUN;
    assign DivConfig = state == CONFIG;
    assign Grant     = (state == RUN) ? ownerOneHot : '0;

endmodule
